// File: rtl/seq_rec_trig_core.sv
// rtl/seq_rec_trig_core.sv - circular-buffer sequence recorder with pre-trigger window and rotated readback
module seq_rec_trig_core #(
  parameter int MEM_BYTES = 1024,
  parameter int ABUSWIDTH = 16,
  parameter int IN_BITS   = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic [IN_BITS-1:0]   SEQ_IN,
  input  logic                 SEQ_EXT_START,
  output logic                 ARMED,
  output logic                 DONE
);

  localparam int IN_BYTES = IN_BITS / 8;
  localparam int DEPTH    = MEM_BYTES / IN_BYTES;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wptr_q, wptr_d, base_q, base_d;
  logic [CW-1:0]       fill_q, fill_d, post_left_q, post_left_d;
  logic [CW-1:0]       cnt_q, cnt_d, pre_q, pre_d;
  logic                done_q, done_d, lost_q, lost_d, prev_q, prev_d;
  logic                en_ext_q, en_ext_d, level_q, level_d;
  logic [7:0]          conf_q, conf_d;
  logic [15:0]         count_q, count_d, pretrig_q, pretrig_d;
  logic [7:0]          rd_reg_q, rd_reg_d;
  logic                rd_mem_sel_q, rd_mem_sel_d;
  logic [1:0]          rd_lane_q, rd_lane_d;
  logic [IN_BITS-1:0]  rd_word_q;

  logic [IN_BITS-1:0]  mem [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [IN_BITS-1:0]  mem_wdata;
  logic [IN_BYTES-1:0] mem_wstrb;

  logic [31:0]         add32, mem_off;
  logic                soft_rst, rst, arm, in_mem, capturing, trig;
  logic [AW-1:0]       bus_idx, rd_phys;
  logic [1:0]          bus_lane;
  logic [16:0]         cnt_eff, pre_eff;
  logic [15:0]         base16;
  logic [7:0]          reg_byte;

  assign add32     = 32'(BUS_ADD);
  assign mem_off   = add32 - 32'd16;
  assign soft_rst  = BUS_WR && (add32 == 32'd0);
  assign rst       = BUS_RST || soft_rst;
  assign arm       = BUS_WR && (add32 == 32'd1);
  assign in_mem    = (add32 >= 32'd16) && (add32 < 32'(16 + MEM_BYTES));
  // byte 0 of a sample is its most significant byte
  assign bus_idx   = AW'(mem_off / IN_BYTES);
  assign bus_lane  = 2'(IN_BYTES - 1 - (mem_off % IN_BYTES));
  assign rd_phys   = base_q + bus_idx;
  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign ARMED     = (state_q == S_PRE) || (state_q == S_WAIT);
  assign DONE      = done_q;
  assign base16    = 16'(base_q);
  assign trig      = !en_ext_q || (level_q ? SEQ_EXT_START : (SEQ_EXT_START && !prev_q));

  // effective capture length and pre-trigger depth, clamped to the buffer
  always_comb begin
    cnt_eff = 17'(DEPTH);
    if (count_q != 16'd0 && {1'b0, count_q} <= 17'(DEPTH)) cnt_eff = {1'b0, count_q};
    pre_eff = {1'b0, pretrig_q};
    if ({1'b0, pretrig_q} >= cnt_eff) pre_eff = cnt_eff - 17'd1;
  end

  // register read mux for the current address
  always_comb begin
    reg_byte = 8'h00;
    case (add32)
      32'd0:   reg_byte = 8'h01;
      32'd1:   reg_byte = {5'b0, lost_q, ARMED, done_q};
      32'd2:   reg_byte = conf_q;
      32'd3:   reg_byte = count_q[7:0];
      32'd4:   reg_byte = count_q[15:8];
      32'd5:   reg_byte = pretrig_q[7:0];
      32'd6:   reg_byte = pretrig_q[15:8];
      32'd7:   reg_byte = base16[7:0];
      32'd8:   reg_byte = base16[15:8];
      default: reg_byte = 8'h00;
    endcase
  end

  // capture FSM, register writes, memory write arbitration and read capture
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    base_d       = base_q;
    fill_d       = fill_q;
    post_left_d  = post_left_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    done_d       = done_q;
    lost_d       = lost_q;
    prev_d       = SEQ_EXT_START;
    en_ext_d     = en_ext_q;
    level_d      = level_q;
    conf_d       = conf_q;
    count_d      = count_q;
    pretrig_d    = pretrig_q;
    rd_reg_d     = rd_reg_q;
    rd_mem_sel_d = rd_mem_sel_q;
    rd_lane_d    = rd_lane_q;
    mem_we       = 1'b0;
    mem_waddr    = bus_idx;
    mem_wdata    = {IN_BYTES{BUS_DATA_IN}};
    mem_wstrb    = IN_BYTES'(1) << bus_lane;

    if (BUS_WR) begin
      case (add32)
        32'd2:   conf_d          = BUS_DATA_IN;
        32'd3:   count_d[7:0]    = BUS_DATA_IN;
        32'd4:   count_d[15:8]   = BUS_DATA_IN;
        32'd5:   pretrig_d[7:0]  = BUS_DATA_IN;
        32'd6:   pretrig_d[15:8] = BUS_DATA_IN;
        default: ;
      endcase
      if (in_mem && !capturing) mem_we = 1'b1;
    end

    if (capturing) begin
      mem_we    = 1'b1;
      mem_waddr = wptr_q;
      mem_wdata = SEQ_IN;
      mem_wstrb = '1;
      wptr_d    = wptr_q + AW'(1);
    end

    case (state_q)
      S_PRE: begin
        fill_d = fill_q + CW'(1);
        if (trig) lost_d = 1'b1;
        if (fill_q + CW'(1) == pre_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (trig) begin
          base_d = wptr_q - AW'(pre_q);
          if (cnt_q - pre_q == CW'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_POST;
            post_left_d = cnt_q - pre_q - CW'(1);
          end
        end
      end
      S_POST: begin
        post_left_d = post_left_q - CW'(1);
        if (post_left_q == CW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // ARM restarts any capture in progress and wins over a same-cycle trigger
    if (arm) begin
      state_d  = (pre_eff == 17'd0) ? S_WAIT : S_PRE;
      done_d   = 1'b0;
      lost_d   = 1'b0;
      wptr_d   = '0;
      fill_d   = '0;
      cnt_d    = CW'(cnt_eff);
      pre_d    = CW'(pre_eff);
      en_ext_d = conf_q[0];
      level_d  = conf_q[1];
      mem_we   = 1'b0;
    end

    if (BUS_RD) begin
      rd_mem_sel_d = in_mem;
      rd_lane_d    = bus_lane;
      rd_reg_d     = reg_byte;
    end
  end

  // state registers with hard or soft synchronous reset
  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      base_q       <= '0;
      fill_q       <= '0;
      post_left_q  <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      done_q       <= 1'b1;
      lost_q       <= 1'b0;
      prev_q       <= 1'b0;
      en_ext_q     <= 1'b0;
      level_q      <= 1'b0;
      conf_q       <= 8'h00;
      count_q      <= 16'(DEPTH);
      pretrig_q    <= 16'h0000;
      rd_reg_q     <= 8'h00;
      rd_mem_sel_q <= 1'b0;
      rd_lane_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      post_left_q  <= post_left_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
      prev_q       <= prev_d;
      en_ext_q     <= en_ext_d;
      level_q      <= level_d;
      conf_q       <= conf_d;
      count_q      <= count_d;
      pretrig_q    <= pretrig_d;
      rd_reg_q     <= rd_reg_d;
      rd_mem_sel_q <= rd_mem_sel_d;
      rd_lane_q    <= rd_lane_d;
    end
  end

  // sample buffer with byte-lane writes and registered rotated read
  always_ff @(posedge BUS_CLK) begin
    if (mem_we && !rst) begin
      for (int l = 0; l < IN_BYTES; l++) begin
        if (mem_wstrb[l]) mem[mem_waddr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
      end
    end
    if (BUS_RD) rd_word_q <= mem[rd_phys];
  end

  // output byte from the address presented on the previous read
  always_comb begin
    BUS_DATA_OUT = rd_reg_q;
    if (rd_mem_sel_q) BUS_DATA_OUT = 8'(rd_word_q >> {rd_lane_q, 3'b000});
  end

endmodule

// File: tb/tb_seq_rec_trig_core.sv
// tb/tb_seq_rec_trig_core.sv - scoreboard bench for seq_rec_trig_core against a post-hoc capture model
module tb_seq_rec_trig_core;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] add = 16'h0;
  logic [7:0]  din = 8'h0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  dout;
  logic [15:0] seq_in = 16'h0;
  logic        ext = 1'b0;
  logic        armed, done;

  int tests = 0;
  int fails = 0;
  int n = 0;
  logic [15:0] hist_seq [8192];
  logic        hist_ext [8192];
  logic        force_en = 1'b0;
  logic [15:0] force_val = 16'h0;
  logic        rd_flag = 1'b0;
  logic [7:0]  exp_q [$];
  string       name_q [$];

  seq_rec_trig_core #(.MEM_BYTES(64), .ABUSWIDTH(16), .IN_BITS(16)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(add), .BUS_DATA_IN(din),
    .BUS_RD(rd), .BUS_WR(wr), .BUS_DATA_OUT(dout),
    .SEQ_IN(seq_in), .SEQ_EXT_START(ext), .ARMED(armed), .DONE(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // record what the DUT samples on each edge; edge index = n before increment
  always @(posedge clk) begin
    hist_seq[n] = seq_in;
    hist_ext[n] = ext;
    n = n + 1;
  end

  always @(negedge clk) seq_in = force_en ? force_val : 16'($urandom);

  always @(posedge clk) rd_flag <= rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: one expected byte per completed read
  always @(negedge clk) begin
    if (rd_flag) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL read_unexpected: got 0x%0h expected none", dout);
      end else begin
        check(name_q.pop_front(), {24'h0, dout}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int a, input int d);
    add = 16'(a); din = 8'(d); wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_exp(input int a, input int e, input string nm);
    exp_q.push_back(8'(e));
    name_q.push_back(nm);
    add = 16'(a); rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic arm_cap(output int a);
    wr_reg(1, 0);
    a = n - 1;
  endtask

  // make edge a+k sample SEQ_EXT_START high, optionally forcing SEQ_IN there
  task automatic pulse_at(input int a, input int k, input bit frc, input logic [15:0] fv);
    while (n - 1 < a + k - 1) tick();
    ext = 1'b1; force_en = frc; force_val = fv;
    tick();
    ext = 1'b0; force_en = 1'b0;
  endtask

  function automatic int find_trig(input int a, input int pre, input bit en_ext, input bit level,
                                   output bit lost);
    bit t;
    lost = 1'b0;
    for (int e = a + 1; e < n; e++) begin
      t = !en_ext ? 1'b1 : (level ? hist_ext[e] : (hist_ext[e] && !hist_ext[e-1]));
      if (e < a + 1 + pre) begin
        if (t) lost = 1'b1;
      end else if (t) begin
        return e;
      end
    end
    return -1;
  endfunction

  // wait for DONE, then check timing, status, BASE and the rotated buffer
  task automatic verify(input int a, input int count, input int pretrig, input bit en_ext,
                        input bit level, input string tag);
    int cnt, pre, t, d, base;
    bit lost;
    logic [15:0] w;
    cnt = (count == 0 || count > DEPTH) ? DEPTH : count;
    pre = (pretrig >= cnt) ? cnt - 1 : pretrig;
    d = -1;
    if (done === 1'b1) d = n - 1;
    for (int i = 0; i < 400 && d < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) d = n - 1;
    end
    t = find_trig(a, pre, en_ext, level, lost);
    check({tag, "_done_edge"}, 32'(d - a), 32'(t + cnt - pre - 1 - a));
    if (t < 0) return;
    base = ((t - (a + 1) - pre) % DEPTH + DEPTH) % DEPTH;
    rd_exp(1, {5'b0, lost, 2'b01}, {tag, "_status"});
    rd_exp(7, base, {tag, "_base_lo"});
    rd_exp(8, 0, {tag, "_base_hi"});
    for (int o = 0; o < 2 * cnt; o++) begin
      w = hist_seq[t - pre + o / 2];
      rd_exp(16 + o, (o % 2 == 0) ? int'(w[15:8]) : int'(w[7:0]), $sformatf("%s_mem%0d", tag, o));
    end
  endtask

  initial begin
    int a, a2, cnt_r, pre_r, c_r, p_r;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_done_pin", {31'h0, done}, 32'h1);
    check("rst_armed_pin", {31'h0, armed}, 32'h0);
    rd_exp(0, 8'h01, "rst_version");
    rd_exp(1, 8'h01, "rst_status");
    rd_exp(2, 8'h00, "rst_conf");
    rd_exp(3, DEPTH, "rst_count_lo");
    rd_exp(4, 0, "rst_count_hi");
    rd_exp(5, 0, "rst_pretrig_lo");
    rd_exp(9, 0, "rst_addr9");
    rd_exp(200, 0, "rst_addr200");

    // 1: automatic trigger, no pre-trigger window
    wr_reg(2, 0); wr_reg(3, 10); wr_reg(4, 0); wr_reg(5, 0); wr_reg(6, 0);
    arm_cap(a);
    verify(a, 10, 0, 1'b0, 1'b0, "t1");

    // 2: edge trigger 50 cycles after ARM with a marker sample
    wr_reg(2, 1); wr_reg(3, 20); wr_reg(5, 8);
    arm_cap(a);
    check("t2_armed_pin", {31'h0, armed}, 32'h1);
    check("t2_done_pin", {31'h0, done}, 32'h0);
    pulse_at(a, 51, 1'b1, 16'hA5A5);
    verify(a, 20, 8, 1'b1, 1'b0, "t2");
    rd_exp(32, 8'hA5, "t2_marker_hi");
    rd_exp(33, 8'hA5, "t2_marker_lo");

    // 3: early trigger is lost, later trigger captures
    wr_reg(3, 16);
    arm_cap(a);
    pulse_at(a, 3, 1'b0, 16'h0);
    pulse_at(a, 20, 1'b0, 16'h0);
    verify(a, 16, 8, 1'b1, 1'b0, "t3");
    rd_exp(1, 8'h05, "t3_lost_status");

    // 4: level trigger held high from before ARM
    wr_reg(2, 3); wr_reg(3, 12); wr_reg(5, 4);
    ext = 1'b1;
    tick(); tick();
    arm_cap(a);
    verify(a, 12, 4, 1'b1, 1'b1, "t4");
    rd_exp(7, 0, "t4_base_zero");
    ext = 1'b0;
    tick();

    // 5: clamped count/pretrig, wrap of the write pointer
    wr_reg(2, 1); wr_reg(3, 0); wr_reg(5, 40);
    arm_cap(a);
    pulse_at(a, 71, 1'b0, 16'h0);
    verify(a, 0, 40, 1'b1, 1'b0, "t5");
    rd_exp(7, 7, "t5_base_wrap");

    // randomized edge-triggered captures
    for (int i = 0; i < 3; i++) begin
      c_r = $urandom_range(0, 40);
      p_r = $urandom_range(0, 40);
      cnt_r = (c_r == 0 || c_r > DEPTH) ? DEPTH : c_r;
      pre_r = (p_r >= cnt_r) ? cnt_r - 1 : p_r;
      wr_reg(3, c_r); wr_reg(5, p_r);
      arm_cap(a);
      if (pre_r >= 2 && $urandom_range(0, 1) == 1) pulse_at(a, 1, 1'b0, 16'h0);
      pulse_at(a, pre_r + 1 + $urandom_range(0, 20), 1'b0, 16'h0);
      verify(a, c_r, p_r, 1'b1, 1'b0, $sformatf("rnd%0d", i));
    end

    // 6: soft reset mid-capture, bus memory writes only when idle
    wr_reg(2, 0); wr_reg(3, 10); wr_reg(5, 0);
    arm_cap(a);
    tick(); tick(); tick();
    wr_reg(0, 0);
    check("t6_done_pin", {31'h0, done}, 32'h1);
    check("t6_armed_pin", {31'h0, armed}, 32'h0);
    rd_exp(1, 8'h01, "t6_status");
    rd_exp(3, DEPTH, "t6_count_lo");
    rd_exp(4, 0, "t6_count_hi");
    rd_exp(2, 0, "t6_conf");
    wr_reg(16, 8'h3C);
    rd_exp(16, 8'h3C, "t6_idle_write");
    rd_exp(17, hist_seq[a + 1][7:0], "t6_other_lane");
    wr_reg(2, 1); wr_reg(3, 10);
    arm_cap(a2);
    tick();
    wr_reg(16, 8'h77);
    tick(); tick();
    wr_reg(0, 0);
    rd_exp(16, hist_seq[a2 + 1][15:8], "t6_armed_write_ignored");

    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
